// File: rtl/addsub_arbiter_pkg.sv
// rtl/addsub_arbiter_pkg.sv - shared defaults, buffer state encoding and round-robin pick helper
package addsub_arbiter_pkg;

  localparam int NBIT_DEF  = 16;
  localparam int NREQ_DEF  = 2;
  localparam int REQ_MAX   = 32;
  localparam int IDX_MAX_W = 5;
  localparam int IDX_W1    = IDX_MAX_W + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic                 found;
    logic [IDX_MAX_W-1:0] idx;
  } pick_t;

  // First set bit of valid at or after ptr, wrapping at nreq back to 0.
  function automatic pick_t rr_pick(input logic [REQ_MAX-1:0]   valid,
                                    input logic [IDX_MAX_W-1:0] ptr,
                                    input logic [IDX_MAX_W:0]   nreq);
    pick_t               p;
    logic [IDX_MAX_W:0]  idx;
    p = '0;
    for (int k = 0; k < REQ_MAX; k++) begin
      idx = {1'b0, ptr} + IDX_W1'(k);
      if (idx >= nreq) idx = idx - nreq;
      if ((IDX_W1'(k) < nreq) && !p.found && valid[idx[IDX_MAX_W-1:0]]) begin
        p.found = 1'b1;
        p.idx   = idx[IDX_MAX_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/addsub_arbiter_add_sub.sv
// rtl/addsub_arbiter_add_sub.sv - shared modulo-2^nBit adder/subtractor (cond=1 -> a-b)
module add_sub #(
  parameter int nBit = 16
) (
  input  logic [nBit-1:0] a,
  input  logic [nBit-1:0] b,
  input  logic            cond,
  output logic [nBit-1:0] result
);

  assign result = cond ? (a - b) : (a + b);

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin share of one add_sub with a one-entry registered result buffer
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int NBIT = NBIT_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*NBIT-1:0] req_a,
  input  logic [NREQ*NBIT-1:0] req_b,
  input  logic [NREQ-1:0]      req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [NBIT-1:0]      rsp_data,
  output logic [IDW-1:0]       rsp_id
);

  state_t          state, state_nx;
  logic [IDW-1:0]  rr_ptr;
  pick_t           pick;
  logic            can_accept;
  logic            fire;
  logic [IDW-1:0]  gnt_id;
  logic [NBIT-1:0] op_a, op_b, op_res;
  logic            op_sub;

  assign pick       = rr_pick(REQ_MAX'(req_valid), IDX_MAX_W'(rr_ptr), IDX_W1'(NREQ));
  assign gnt_id     = pick.idx[IDW-1:0];
  assign can_accept = (state == EMPTY) | rsp_ready;
  assign fire       = can_accept & pick.found;
  assign rsp_valid  = (state == FULL);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = rst_n & fire & (pick.idx == IDX_MAX_W'(i));
  end

  // Operand mux feeding the single shared datapath.
  assign op_a   = req_a[int'(pick.idx)*NBIT +: NBIT];
  assign op_b   = req_b[int'(pick.idx)*NBIT +: NBIT];
  assign op_sub = req_sub[pick.idx];

  add_sub #(.nBit(NBIT)) u_add_sub (
    .a      (op_a),
    .b      (op_b),
    .cond   (op_sub),
    .result (op_res)
  );

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (fire) state_nx = FULL;
      FULL:    if (rsp_ready && !fire) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= '0;
      rr_ptr   <= '0;
    end else if (fire) begin
      rsp_data <= op_res;
      rsp_id   <= gnt_id;
      rr_ptr   <= (pick.idx == IDX_MAX_W'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - directed bench for addsub_arbiter with NBIT=16, NREQ=2
module tb_addsub_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic [1:0]  req_sub;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [0:0]  rsp_id;

  int errors = 0;
  int checks = 0;

  addsub_arbiter #(.NBIT(16), .NREQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [15:0] d, input logic id);
    chk({tag, "_valid"}, 16'(rsp_valid), 16'(v));
    chk({tag, "_data"},  rsp_data, d);
    chk({tag, "_id"},    16'(rsp_id), 16'(id));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b11; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b0;
    #2;
    chk("reset_ready", 16'(req_ready), 16'h0000);
    chk_rsp("reset", 1'b0, 16'h0000, 1'b0);
    tick(); tick();
    rst_n = 1'b1;

    // 1: single op, 5-3
    req_valid = 2'b01; req_a = {16'h0000, 16'h0005}; req_b = {16'h0000, 16'h0003};
    req_sub = 2'b01; rsp_ready = 1'b1;
    #1 chk("t1_ready", 16'(req_ready), 16'h0001);
    tick();
    chk_rsp("t1", 1'b1, 16'h0002, 1'b0);

    // 2: alternation from rr_ptr=0 after a fresh reset
    rst_n = 1'b0; #1 rst_n = 1'b1;
    req_valid = 2'b11; req_a = {16'h0100, 16'h0010}; req_b = {16'h0001, 16'h0001};
    req_sub = 2'b10; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_ready", 16'(req_ready), (i % 2 == 0) ? 16'h0001 : 16'h0002);
      tick();
      chk_rsp("t2", 1'b1, (i % 2 == 0) ? 16'h0011 : 16'h00FF, (i % 2 == 1));
    end

    // 3: wraparound arithmetic
    req_valid = 2'b01; req_a = {16'h0000, 16'hFFFF}; req_b = {16'h0001, 16'h0001}; req_sub = 2'b10;
    #1 chk("t3a_ready", 16'(req_ready), 16'h0001);
    tick();
    chk_rsp("t3a", 1'b1, 16'h0000, 1'b0);
    req_valid = 2'b10;
    #1 chk("t3b_ready", 16'(req_ready), 16'h0002);
    tick();
    chk_rsp("t3b", 1'b1, 16'hFFFF, 1'b1);

    // 4: backpressure holds FFFF/id1, then resumes at rr_ptr=0
    req_valid = 2'b11; rsp_ready = 1'b0;
    req_a = {16'h0100, 16'h1234}; req_b = {16'h0001, 16'h1111}; req_sub = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_hold_ready", 16'(req_ready), 16'h0000);
      tick();
      chk_rsp("t4_hold", 1'b1, 16'hFFFF, 1'b1);
    end
    rsp_ready = 1'b1;
    #1 chk("t4_rel_ready0", 16'(req_ready), 16'h0001);
    tick();
    chk_rsp("t4_rel0", 1'b1, 16'h2345, 1'b0);
    #1 chk("t4_rel_ready1", 16'(req_ready), 16'h0002);
    tick();
    chk_rsp("t4_rel1", 1'b1, 16'h00FF, 1'b1);

    // 5: leave rr_ptr=1 with a buffered result, then reset between edges
    req_valid = 2'b01;
    tick();
    chk_rsp("t5_pre", 1'b1, 16'h2345, 1'b0);
    req_valid = 2'b00; rsp_ready = 1'b0;
    tick();
    #3 rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    chk_rsp("t5_rst", 1'b0, 16'h0000, 1'b0);
    chk("t5_rst_ready", 16'(req_ready), 16'h0000);
    req_valid = 2'b00;
    #2 rst_n = 1'b1;
    tick();
    chk_rsp("t5_after", 1'b0, 16'h0000, 1'b0);
    req_valid = 2'b11; rsp_ready = 1'b1;
    #1 chk("t5_ptr0_ready", 16'(req_ready), 16'h0001);
    tick();
    chk_rsp("t5_grant", 1'b1, 16'h2345, 1'b0);

    // 6: only requester 1 valid, granted every cycle
    req_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t6_ready", 16'(req_ready), 16'h0002);
      tick();
      chk_rsp("t6", 1'b1, 16'h00FF, 1'b1);
    end

    // idle cycles drain the buffer and leave rr_ptr at 0
    req_valid = 2'b00;
    tick(); tick();
    chk("idle_valid", 16'(rsp_valid), 16'h0000);
    req_valid = 2'b11;
    #1 chk("idle_ptr_ready", 16'(req_ready), 16'h0001);
    tick();
    chk_rsp("idle_grant", 1'b1, 16'h2345, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
